// File: rtl/reg_timeout_cut.sv
// Single-entry register-bus cut with a hung-target guard: the request path is registered,
// and if the target stalls for Timeout cycles the block answers upstream itself with error=1.
package reg_timeout_cut_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;
endpackage

module reg_timeout_cut #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter type         req_t    = reg_timeout_cut_pkg::reg_req_t,
   parameter type         rsp_t    = reg_timeout_cut_pkg::reg_rsp_t,
   parameter int unsigned Timeout  = 32,
   parameter logic [31:0] ErrRData = 32'hBADCAB1E
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  req_t in_req_i,
   output rsp_t in_rsp_o,
   output req_t out_req_o,
   input  rsp_t out_rsp_i,
   output logic timeout_o
);

   localparam int unsigned     CW      = (Timeout == 0) ? 1 : $clog2(Timeout + 1);
   localparam logic [CW-1:0]   TmoLast = (Timeout == 0) ? '0 : CW'(Timeout - 1);
   localparam logic [DW-1:0]   ErrData = DW'(ErrRData);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [AW-1:0]   addr_q;
   logic            write_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic [DW-1:0]   rdata_q;
   logic            error_q;
   logic            tmo_hit;

   // A target ready in the final window cycle beats the abort.
   assign tmo_hit   = (Timeout != 0) && (state_q == ISSUE) && (cnt_q == TmoLast) && !out_rsp_i.ready;
   assign timeout_o = tmo_hit && rst_ni;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_req_i.valid) begin
                  addr_q  <= in_req_i.addr;
                  write_q <= in_req_i.write;
                  wdata_q <= in_req_i.wdata;
                  wstrb_q <= in_req_i.wstrb;
                  cnt_q   <= '0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (out_rsp_i.ready) begin
                  rdata_q <= out_rsp_i.rdata;
                  error_q <= out_rsp_i.error;
                  state_q <= RESP;
               end else if (tmo_hit) begin
                  rdata_q <= ErrData;
                  error_q <= 1'b1;
                  state_q <= RESP;
               end else if (Timeout != 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_req_o       = '0;
      out_req_o.addr  = addr_q;
      out_req_o.write = write_q;
      out_req_o.wdata = wdata_q;
      out_req_o.wstrb = wstrb_q;
      out_req_o.valid = (state_q == ISSUE);

      in_rsp_o        = '0;
      in_rsp_o.rdata  = rdata_q;
      in_rsp_o.error  = error_q;
      in_rsp_o.ready  = (state_q == RESP);
   end

`ifndef SYNTHESIS
   a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_req_i.valid && !in_rsp_o.ready) |=>
         $stable({in_req_i.addr, in_req_i.write, in_req_i.wdata, in_req_i.wstrb}));

   a_tmo_in_issue : assert property (@(posedge clk_i) timeout_o |-> (state_q == ISSUE));
`endif

endmodule

// File: tb/tb_reg_timeout_cut.sv
// Scoreboard bench for reg_timeout_cut (Timeout=8): directed transactions against a
// programmable-wait target model, with request- and response-side monitors.
module tb_reg_timeout_cut;
   import reg_timeout_cut_pkg::*;

   logic     clk_i = 1'b0;
   logic     rst_ni = 1'b0;
   reg_req_t in_req_i;
   reg_rsp_t in_rsp_o;
   reg_req_t out_req_o;
   reg_rsp_t out_rsp_i;
   logic     timeout_o;

   always #5 clk_i = ~clk_i;

   reg_timeout_cut #(
      .AW(32), .DW(32), .Timeout(8), .ErrRData(32'hBADCAB1E)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_req_i(in_req_i), .in_rsp_o(in_rsp_o),
      .out_req_o(out_req_o), .out_rsp_i(out_rsp_i),
      .timeout_o(timeout_o)
   );

   typedef struct {
      logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb;
      int wt; logic [31:0] trd; logic terr;
      int ncyc; logic [31:0] erd; logic eerr; logic etmo;
   } vec_t;

   typedef struct {
      logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb; int ncyc;
   } exp_req_t;

   typedef struct {
      logic [31:0] rdata; logic error; logic tmo;
   } exp_rsp_t;

   vec_t     vec[11];
   exp_req_t req_q[$];
   exp_rsp_t rsp_q[$];
   int       rsp_cyc[11];
   int       checks = 0;
   int       failures = 0;
   int       cyc = 0;
   bit       started = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endfunction

   always @(posedge clk_i) cyc++;

   // Target model: ready after tgt_wait cycles counted from the first ISSUE cycle,
   // even if the bridge has already given up (late ready).
   int          tgt_wait = -1;
   logic [31:0] tgt_rdata = '0;
   logic        tgt_err = 1'b0;
   bit          tgt_busy = 0;
   int          tgt_cnt = 0;

   always @(posedge clk_i) begin
      #2;
      if (!tgt_busy && out_req_o.valid) begin
         tgt_busy = 1;
         tgt_cnt  = 0;
      end else if (tgt_busy) begin
         tgt_cnt++;
      end
      if (tgt_busy && tgt_wait >= 0 && tgt_cnt == tgt_wait) begin
         out_rsp_i = '{rdata: tgt_rdata, error: tgt_err, ready: 1'b1};
         tgt_busy  = 0;
      end else begin
         out_rsp_i = '{rdata: 32'hFFFF_FFFF, error: 1'b1, ready: 1'b0};
      end
   end

   // Request-side monitor: payload on the first valid cycle, run length when valid drops.
   int       run = 0;
   exp_req_t cur;
   always @(negedge clk_i) begin
      if (started) begin
         if (out_req_o.valid) begin
            if (run == 0) begin
               cur = '{out_req_o.addr, out_req_o.write, out_req_o.wdata, out_req_o.wstrb, 0};
            end
            run++;
         end else if (run > 0) begin
            if (req_q.size() == 0) begin
               chk("req_unexpected", 64'(run), 64'd0);
            end else begin
               exp_req_t e;
               e = req_q.pop_front();
               chk("req_addr", cur.addr, e.addr);
               chk("req_write", cur.write, e.write);
               chk("req_wdata", cur.wdata, e.wdata);
               chk("req_wstrb", cur.wstrb, e.wstrb);
               chk("req_cycles", 64'(run), 64'(e.ncyc));
            end
            run = 0;
         end
      end
   end

   // Response-side monitor.
   logic tmo_prev = 1'b0;
   logic rdy_prev = 1'b0;
   always @(negedge clk_i) begin
      if (started) begin
         if (in_rsp_o.ready) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               exp_rsp_t e;
               e = rsp_q.pop_front();
               chk("rsp_rdata", in_rsp_o.rdata, e.rdata);
               chk("rsp_error", in_rsp_o.error, e.error);
               chk("rsp_timeout", tmo_prev, e.tmo);
               chk("rsp_single", rdy_prev, 1'b0);
            end
         end
         tmo_prev = timeout_o;
         rdy_prev = in_rsp_o.ready;
      end
   end

   task automatic drive_req(input int i);
      exp_req_t er;
      er = '{vec[i].addr, vec[i].write, vec[i].wdata, vec[i].wstrb, vec[i].ncyc};
      req_q.push_back(er);
      tgt_wait        = vec[i].wt;
      tgt_rdata       = vec[i].trd;
      tgt_err         = vec[i].terr;
      tgt_busy        = 0;
      in_req_i.addr   = vec[i].addr;
      in_req_i.write  = vec[i].write;
      in_req_i.wdata  = vec[i].wdata;
      in_req_i.wstrb  = vec[i].wstrb;
      in_req_i.valid  = 1'b1;
   endtask

   // Leaves valid asserted on return; the cycle after is the IDLE cycle following RESP.
   task automatic issue(input int i);
      exp_rsp_t es;
      bit got;
      int n;
      es = '{vec[i].erd, vec[i].eerr, vec[i].etmo};
      rsp_q.push_back(es);
      drive_req(i);
      got = 0;
      n   = 0;
      while (n < 40 && !got) begin
         @(posedge clk_i); #1;
         n++;
         if (in_rsp_o.ready) got = 1;
      end
      chk("rsp_wait", 64'(got), 64'd1);
      rsp_cyc[i] = cyc;
      @(posedge clk_i); #1;
   endtask

   initial begin
      //          addr          wr    wdata          wstrb  wt  trd            terr  ncyc erd            eerr  etmo
      vec[0]  = '{32'h0000_0010, 1'b1, 32'hCAFE_F00D, 4'hF,  0, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 1'b0, 1'b0};
      vec[1]  = '{32'h0000_0020, 1'b0, 32'h0000_0000, 4'h0,  5, 32'h1234_5678, 1'b0, 6, 32'h1234_5678, 1'b0, 1'b0};
      vec[2]  = '{32'h0000_0030, 1'b0, 32'h0000_0000, 4'h0, -1, 32'h0000_0000, 1'b0, 8, 32'hBADC_AB1E, 1'b1, 1'b1};
      vec[3]  = '{32'h0000_0034, 1'b0, 32'h0000_0000, 4'h0,  7, 32'hA5A5_0007, 1'b0, 8, 32'hA5A5_0007, 1'b0, 1'b0};
      vec[4]  = '{32'h0000_0038, 1'b0, 32'h0000_0000, 4'h0,  8, 32'h5A5A_0008, 1'b0, 8, 32'hBADC_AB1E, 1'b1, 1'b1};
      vec[5]  = '{32'h0000_0040, 1'b1, 32'h0000_BEEF, 4'h3,  2, 32'hDEAD_0001, 1'b1, 3, 32'hDEAD_0001, 1'b1, 1'b0};
      vec[6]  = '{32'h0000_0050, 1'b1, 32'h1111_1111, 4'h1,  0, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 1'b0, 1'b0};
      vec[7]  = '{32'h0000_0054, 1'b0, 32'h0000_0000, 4'h0,  0, 32'h7777_7777, 1'b0, 1, 32'h7777_7777, 1'b0, 1'b0};
      vec[8]  = '{32'h0000_0058, 1'b1, 32'h3333_3333, 4'h8,  0, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 1'b0, 1'b0};
      vec[9]  = '{32'h0000_0060, 1'b0, 32'h0000_0000, 4'h0, -1, 32'h0000_0000, 1'b0, 3, 32'h0000_0000, 1'b0, 1'b0};
      vec[10] = '{32'h0000_0064, 1'b0, 32'h0000_0000, 4'h0,  1, 32'h0F0F_0F0F, 1'b0, 2, 32'h0F0F_0F0F, 1'b0, 1'b0};

      in_req_i  = '0;
      out_rsp_i = '{rdata: 32'hFFFF_FFFF, error: 1'b1, ready: 1'b0};

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_out_valid", out_req_o.valid, 1'b0);
      chk("rst_in_ready", in_rsp_o.ready, 1'b0);
      chk("rst_timeout", timeout_o, 1'b0);
      chk("rst_out_addr", out_req_o.addr, 32'h0);
      chk("rst_in_rdata", in_rsp_o.rdata, 32'h0);
      @(posedge clk_i); #1;
      rst_ni  = 1'b1;
      started = 1;
      @(posedge clk_i); #1;

      for (int i = 0; i <= 5; i++) begin
         issue(i);
         in_req_i.valid = 1'b0;
         @(posedge clk_i); #1;
      end

      issue(6);
      issue(7);
      issue(8);
      in_req_i.valid = 1'b0;
      chk("b2b_spacing_1", 64'(rsp_cyc[7] - rsp_cyc[6]), 64'd3);
      chk("b2b_spacing_2", 64'(rsp_cyc[8] - rsp_cyc[7]), 64'd3);
      @(posedge clk_i); #1;

      // Reset lands in the third ISSUE cycle of a hung transaction; no response may follow.
      drive_req(9);
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      rst_ni         = 1'b0;
      in_req_i.valid = 1'b0;
      @(posedge clk_i); #1;
      rst_ni   = 1'b1;
      tgt_busy = 0;
      @(negedge clk_i);
      chk("midrst_out_valid", out_req_o.valid, 1'b0);
      chk("midrst_in_ready", in_rsp_o.ready, 1'b0);
      @(posedge clk_i); #1;

      issue(10);
      in_req_i.valid = 1'b0;

      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      chk("req_q_drained", 64'(req_q.size()), 64'd0);
      chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
